// File: rtl/imem_boot_sequencer_pkg.sv
// Shared types and constants for the instruction-memory boot/test sequencer.
package imem_boot_pkg;

  typedef enum logic [2:0] {IDLE, HDR, LOAD, RUN, DONE} state_t;

  localparam logic [2:0] ST_NONE    = 3'd0;
  localparam logic [2:0] ST_PASS    = 3'd1;
  localparam logic [2:0] ST_FAIL    = 3'd2;
  localparam logic [2:0] ST_TIMEOUT = 3'd3;
  localparam logic [2:0] ST_BADLEN  = 3'd4;

  // riscv-tests exit syscall number placed in a7
  localparam int ECALL_EXIT = 93;

endpackage

// File: rtl/imem_boot_sequencer_if.sv
// Byte-stream input and instruction-memory load port of the boot sequencer.
interface imem_boot_sequencer_if #(parameter int WIDTH = 32);
  logic             rx_valid;
  logic [7:0]       rx_data;
  logic             rx_ready;
  logic             ins_mem_en;
  logic [WIDTH-1:0] ins_mem_data;
  logic [WIDTH-1:0] ins_mem_addr;

  modport master (input rx_valid, rx_data,
                  output rx_ready, ins_mem_en, ins_mem_data, ins_mem_addr);
  modport slave  (output rx_valid, rx_data,
                  input rx_ready, ins_mem_en, ins_mem_data, ins_mem_addr);
endinterface

// File: rtl/imem_boot_sequencer_byte_word_assembler.sv
// Packs a little-endian byte stream into 32-bit words; word_valid pulses the
// cycle after the fourth byte of each word.
module byte_word_assembler (
  input  logic        clock,
  input  logic        reset,
  input  logic        clear,
  input  logic        byte_valid,
  input  logic [7:0]  byte_data,
  output logic [31:0] word,
  output logic        word_valid
);

  logic [1:0] cnt;

  // Shifting in from the top leaves the first byte in bits [7:0].
  always_ff @(posedge clock) begin
    if (reset || clear) begin
      word       <= '0;
      cnt        <= '0;
      word_valid <= 1'b0;
    end else begin
      word_valid <= byte_valid && (cnt == 2'd3);
      if (byte_valid) begin
        word <= {byte_data, word[31:8]};
        cnt  <= cnt + 2'd1;
      end
    end
  end

endmodule

// File: rtl/imem_boot_sequencer.sv
// Loads a byte-streamed program into core instruction memory, runs the core
// and reports the riscv-tests exit result with the run-phase cycle count.
module imem_boot_sequencer
  import imem_boot_pkg::*;
#(
  parameter int WIDTH      = 32,
  parameter int IMEM_DEPTH = 512,
  parameter int MAX_CYCLES = 100000,
  parameter int CNT_W      = 32
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 start,
  imem_boot_sequencer_if.master bus,
  output logic                 core_reset,
  input  logic [WIDTH-1:0]     core_gp,
  input  logic [WIDTH-1:0]     core_a7,
  output logic                 busy,
  output logic                 done,
  output logic [2:0]           status,
  output logic [WIDTH-2:0]     fail_test,
  output logic [CNT_W-1:0]     cycle_count
);

  state_t           state, next_state;
  logic [31:0]      asm_word;
  logic             asm_valid, asm_clear, byte_acc;
  logic [31:0]      n_words, idx;
  logic [WIDTH-1:0] a7_prev;
  logic             hdr_bad, last_word, exit_hit, timeout_hit;

  assign byte_acc    = bus.rx_valid & bus.rx_ready;
  assign hdr_bad     = (asm_word == 32'd0) || (asm_word > 32'(IMEM_DEPTH));
  assign last_word   = (idx == n_words - 32'd1);
  // Core registers survive core reset, so only a fresh write of 93 counts.
  assign exit_hit    = (core_a7 == WIDTH'(ECALL_EXIT)) && (a7_prev != WIDTH'(ECALL_EXIT));
  assign timeout_hit = (cycle_count == CNT_W'(MAX_CYCLES - 1));

  byte_word_assembler u_asm (
    .clock      (clock),
    .reset      (reset),
    .clear      (asm_clear),
    .byte_valid (byte_acc),
    .byte_data  (bus.rx_data),
    .word       (asm_word),
    .word_valid (asm_valid)
  );

  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE: if (start) next_state = HDR;
      HDR:  if (asm_valid) next_state = hdr_bad ? DONE : LOAD;
      LOAD: if (asm_valid && last_word) next_state = RUN;
      RUN:  if (exit_hit || timeout_hit) next_state = DONE;
      DONE: if (start) next_state = HDR;
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    bus.rx_ready     = (state == HDR) || (state == LOAD);
    bus.ins_mem_en   = (state == LOAD) && asm_valid;
    bus.ins_mem_data = WIDTH'(asm_word);
    bus.ins_mem_addr = WIDTH'(idx);
    busy             = (state == HDR) || (state == LOAD) || (state == RUN);
    done             = (state == DONE);
    asm_clear        = start && ((state == IDLE) || (state == DONE));
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      core_reset  <= 1'b1;
      n_words     <= '0;
      idx         <= '0;
      a7_prev     <= '0;
      status      <= ST_NONE;
      fail_test   <= '0;
      cycle_count <= '0;
    end else begin
      // Registered from next_state so release lines up with the first RUN cycle.
      core_reset <= (next_state != RUN);
      a7_prev    <= core_a7;
      if (asm_clear) begin
        status    <= ST_NONE;
        fail_test <= '0;
      end
      if (state == HDR && asm_valid) begin
        n_words <= asm_word;
        idx     <= '0;
        if (hdr_bad) status <= ST_BADLEN;
      end
      if (bus.ins_mem_en) idx <= idx + 32'd1;
      if (next_state == RUN)
        cycle_count <= (state == RUN) ? cycle_count + CNT_W'(1) : '0;
      if (state == RUN) begin
        if (exit_hit) begin
          if (core_gp == WIDTH'(1)) begin
            status <= ST_PASS;
          end else begin
            status    <= ST_FAIL;
            fail_test <= core_gp[WIDTH-1:1];
          end
        end else if (timeout_hit) begin
          status <= ST_TIMEOUT;
        end
      end
    end
  end

endmodule

// File: tb/tb_imem_boot_sequencer.sv
// Scoreboard bench: stimulus queues expected events, a monitor checks them as
// the sequencer writes imem, releases the core and finishes.
module tb_imem_boot_sequencer;
  import imem_boot_pkg::*;

  localparam int WIDTH = 32;
  localparam int CNT_W = 32;
  localparam int EV_WR = 0, EV_CRFALL = 1, EV_DONE = 2;

  typedef struct {
    int          kind;
    logic [31:0] a, b, c;
  } ev_t;

  logic             clock, reset, start;
  logic             core_reset, busy, done;
  logic [WIDTH-1:0] core_gp, core_a7;
  logic [2:0]       status;
  logic [WIDTH-2:0] fail_test;
  logic [CNT_W-1:0] cycle_count;

  imem_boot_sequencer_if #(.WIDTH(WIDTH)) bus ();

  imem_boot_sequencer #(.WIDTH(WIDTH), .IMEM_DEPTH(512), .MAX_CYCLES(50), .CNT_W(CNT_W)) dut (
    .clock       (clock),
    .reset       (reset),
    .start       (start),
    .bus         (bus),
    .core_reset  (core_reset),
    .core_gp     (core_gp),
    .core_a7     (core_a7),
    .busy        (busy),
    .done        (done),
    .status      (status),
    .fail_test   (fail_test),
    .cycle_count (cycle_count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  ev_t sb_q[$];
  int  n_checks = 0;
  int  n_fail   = 0;
  int  cyc = 0, last_wr = 0;
  logic cr_prev = 1'b1, done_prev = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic bound_fail(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s: wait bound expired", name);
  endtask

  // Monitor: pop and compare whenever the DUT presents an observable event.
  always @(negedge clock) begin
    ev_t e;
    cyc++;
    if (!reset) begin
      if (bus.ins_mem_en) begin
        last_wr = cyc;
        if (sb_q.size() == 0) chk("unexpected imem write", 32'd1, 32'd0);
        else begin
          e = sb_q.pop_front();
          chk("event kind at imem write", EV_WR, e.kind);
          chk("imem addr", bus.ins_mem_addr, e.a);
          chk("imem data", bus.ins_mem_data, e.b);
        end
      end
      if (cr_prev && !core_reset) begin
        if (sb_q.size() == 0) chk("unexpected core release", 32'd1, 32'd0);
        else begin
          e = sb_q.pop_front();
          chk("event kind at core release", EV_CRFALL, e.kind);
          chk("core release delay after last write", cyc - last_wr, e.a);
        end
      end
      if (done && !done_prev) begin
        if (sb_q.size() == 0) chk("unexpected done", 32'd1, 32'd0);
        else begin
          e = sb_q.pop_front();
          chk("event kind at done", EV_DONE, e.kind);
          chk("status", 32'(status), e.a);
          chk("fail_test", 32'(fail_test), e.b);
          chk("cycle_count", cycle_count, e.c);
          chk("core_reset in DONE", 32'(core_reset), 32'd1);
          chk("busy in DONE", 32'(busy), 32'd0);
        end
      end
    end
    cr_prev   = core_reset;
    done_prev = done;
  end

  task automatic send_byte(input logic [7:0] b);
    int n = 0;
    @(negedge clock);
    bus.rx_valid = 1'b1;
    bus.rx_data  = b;
    while (!bus.rx_ready && n < 100) begin
      @(negedge clock);
      n++;
    end
    if (!bus.rx_ready) bound_fail("rx_ready");
    @(posedge clock);
    #1 bus.rx_valid = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w);
    for (int i = 0; i < 4; i++) send_byte(w[8*i +: 8]);
  endtask

  task automatic load_word(input logic [31:0] addr, input logic [31:0] w);
    sb_q.push_back('{EV_WR, addr, w, 32'd0});
    send_word(w);
  endtask

  task automatic pulse_start();
    @(negedge clock);
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
  endtask

  task automatic wait_run();
    int n = 0;
    while (core_reset && n < 200) begin
      @(negedge clock);
      n++;
    end
    if (core_reset) bound_fail("core release");
  endtask

  task automatic wait_done();
    int n = 0;
    while (!done && n < 1000) begin
      @(negedge clock);
      n++;
    end
    if (!done) bound_fail("done");
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, " core_reset"}, 32'(core_reset), 32'd1);
    chk({tag, " rx_ready"}, 32'(bus.rx_ready), 32'd0);
    chk({tag, " ins_mem_en"}, 32'(bus.ins_mem_en), 32'd0);
    chk({tag, " ins_mem_data"}, bus.ins_mem_data, 32'd0);
    chk({tag, " ins_mem_addr"}, bus.ins_mem_addr, 32'd0);
    chk({tag, " busy"}, 32'(busy), 32'd0);
    chk({tag, " done"}, 32'(done), 32'd0);
    chk({tag, " status"}, 32'(status), 32'd0);
    chk({tag, " fail_test"}, 32'(fail_test), 32'd0);
    chk({tag, " cycle_count"}, cycle_count, 32'd0);
  endtask

  // Two-word program; exit at RUN cycle exit_at (negative = never).
  task automatic run_two_word(input int exit_at, input logic [31:0] gp,
                              input logic [2:0] exp_st, input logic [31:0] exp_ft,
                              input logic [31:0] exp_cc);
    core_gp = gp;
    pulse_start();
    send_word(32'd2);
    load_word(32'd0, 32'h0000_0013);
    load_word(32'd1, 32'h05D0_0893);
    sb_q.push_back('{EV_CRFALL, 32'd1, 32'd0, 32'd0});
    sb_q.push_back('{EV_DONE, 32'(exp_st), exp_ft, exp_cc});
    wait_run();
    if (exit_at >= 0) begin
      repeat (exit_at) @(negedge clock);
      core_a7 = 32'd93;
    end
    wait_done();
  endtask

  initial begin
    reset = 1'b1;
    start = 1'b0;
    bus.rx_valid = 1'b0;
    bus.rx_data  = 8'h00;
    core_gp = '0;
    core_a7 = '0;
    repeat (3) @(negedge clock);
    check_reset_vals("reset");
    reset = 1'b0;

    // Load then pass at RUN cycle 40.
    run_two_word(40, 32'd1, ST_PASS, 32'd0, 32'd40);
    // Same program, gp = 7 -> test 3 fails.
    core_a7 = '0;
    run_two_word(40, 32'd7, ST_FAIL, 32'd3, 32'd40);
    // a7 already 93 at RUN entry: no edge, timeout at MAX_CYCLES-1.
    core_a7 = 32'd93;
    run_two_word(-1, 32'd1, ST_TIMEOUT, 32'd0, 32'd49);

    // Bad headers; cycle_count stays at the previous run's value.
    sb_q.push_back('{EV_DONE, 32'(ST_BADLEN), 32'd0, 32'd49});
    pulse_start();
    send_word(32'd0);
    wait_done();
    sb_q.push_back('{EV_DONE, 32'(ST_BADLEN), 32'd0, 32'd49});
    pulse_start();
    send_word(32'd513);
    wait_done();
    chk("core_reset after BADLEN", 32'(core_reset), 32'd1);

    // Abort a three-word load after word 0 plus a partial word.
    core_a7 = '0;
    core_gp = 32'd1;
    pulse_start();
    send_word(32'd3);
    load_word(32'd0, 32'h0000_0013);
    send_byte(8'h93);
    send_byte(8'h08);
    @(negedge clock);
    reset = 1'b1;
    repeat (2) @(negedge clock);
    check_reset_vals("mid-load reset");
    reset = 1'b0;

    // Full reload with ignored start pulses in LOAD and RUN.
    pulse_start();
    send_word(32'd3);
    load_word(32'd0, 32'h0000_0013);
    pulse_start();
    load_word(32'd1, 32'h05D0_0893);
    load_word(32'd2, 32'h0000_0073);
    sb_q.push_back('{EV_CRFALL, 32'd1, 32'd0, 32'd0});
    sb_q.push_back('{EV_DONE, 32'(ST_PASS), 32'd0, 32'd10});
    wait_run();
    repeat (5) @(negedge clock);
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    repeat (4) @(negedge clock);
    core_a7 = 32'd93;
    wait_done();

    repeat (3) @(negedge clock);
    chk("scoreboard drained", sb_q.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/imem_boot_sequencer.md
Name: imem_boot_sequencer

Overview:
Boot and test sequencer for the single-cycle RV32 core.
- Holds the core in reset and streams a program, received as a byte stream, into core instruction memory through the core's load port (enable, data, word address).
- Releases the core and watches the core's gp and a7 outputs for the riscv-tests exit convention (a7 = 93).
- Reports pass, fail or timeout, together with the cycle count.

Parameters:
- WIDTH, 32, data/address width of the instruction-memory load port and of gp/a7.
- IMEM_DEPTH, 512, instruction-memory depth in words; the maximum legal program length.
- MAX_CYCLES, 100000, run-phase cycle budget before timeout.
- CNT_W, 32, width of the cycle counter.

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous, active-high reset
- start  in  1  one-cycle pulse; begins load; honoured only in IDLE or DONE
- rx_valid  in  1  byte valid
- rx_data  in  8  program byte; little-endian within each word
- rx_ready  out  1  byte accepted when rx_valid & rx_ready
- core_reset  out  1  drives the core reset
- ins_mem_en  out  1  instruction-memory write enable
- ins_mem_data  out  WIDTH  instruction word to write
- ins_mem_addr  out  WIDTH  word index (not byte address)
- core_gp  in  WIDTH  core register x3
- core_a7  in  WIDTH  core register x17
- busy  out  1  high in HDR, LOAD, RUN
- done  out  1  level; high in DONE
- status  out  3  result code
- fail_test  out  WIDTH-1  failing test number
- cycle_count  out  CNT_W  run-phase cycles

Behaviour:
Reset values:
- core_reset = 1, rx_ready = 0, ins_mem_en = 0.
- ins_mem_data = 0, ins_mem_addr = 0.
- busy = 0, done = 0, status = NONE, fail_test = 0, cycle_count = 0.
- state = IDLE. Reset mid-operation aborts everything to these values; a partial load is abandoned.

Status codes: NONE = 0, PASS = 1, FAIL = 2, TIMEOUT = 3, BADLEN = 4.

States and transitions:
- IDLE: start -> HDR.
- HDR:
  - rx_ready = 1; receives 4 bytes as a little-endian word count N.
  - N == 0 or N > IMEM_DEPTH: -> DONE with status = BADLEN, the cycle after the 4th byte.
  - Otherwise: -> LOAD, with the word index cleared to 0.
- LOAD:
  - rx_ready = 1; every 4 accepted bytes form one word.
  - The cycle after the 4th byte is accepted, ins_mem_en = 1 for exactly one cycle, with ins_mem_data = the word and ins_mem_addr = the current index; the index then increments.
  - rx_ready stays 1 during that write cycle; there is no back-pressure beyond rx_valid gaps.
  - The cycle after writing word N-1: -> RUN.
- RUN:
  - core_reset = 0, rx_ready = 0.
  - cycle_count is cleared on entry and increments by 1 on every RUN cycle; the first RUN cycle reads 0.
  - a7_prev is a registered copy of core_a7.
  - Exit is detected when core_a7 == 93 and a7_prev != 93. Edge detection is required because core registers are not cleared by core reset; the test's start-up code zeroes them.
  - On exit, next cycle -> DONE:
    - core_gp == 1: status = PASS.
    - Otherwise: status = FAIL and fail_test = core_gp[WIDTH-1:1].
  - If cycle_count reaches MAX_CYCLES-1 with no exit: -> DONE with status = TIMEOUT.
  - If an exit and the timeout happen in the same cycle, the exit wins.
- DONE:
  - core_reset = 1, done = 1; status, fail_test and cycle_count are held.
  - start -> HDR, clearing status, done and fail_test.
- start in HDR, LOAD or RUN is ignored.

Additional rules:
- core_reset is registered.
- It is 1 in every state except RUN.
- Its deassertion coincides with the first RUN cycle.

Decomposition:
- Package imem_boot_pkg holds:
  - the state enum (IDLE, HDR, LOAD, RUN, DONE);
  - the status code localparams;
  - ECALL_EXIT = 93.
- One sub-module, byte_word_assembler:
  - accepts bytes, shifts them into a 32-bit little-endian word, keeps a 2-bit byte counter;
  - emits word_valid for one cycle after the 4th byte;
  - has a clear input used on HDR entry and on reset.
  - It is used for both the header and the program words.

Test Plan:
1. start; N = 2; bytes 13 00 00 00, 93 08 D0 05 -> ins_mem_en pulses at addr 0 with 0x00000013, then at addr 1 with 0x05D00893; core_reset falls the next cycle.
2. Load a program whose core_a7 goes 0 -> 93 while core_gp = 1 at RUN cycle 40 -> done = 1, status = PASS, cycle_count = 40, core_reset = 1.
3. Same program but core_gp = 7 -> status = FAIL, fail_test = 3.
4. MAX_CYCLES = 50 and core_a7 held at 93 from RUN entry (no edge) -> status = TIMEOUT at cycle_count = 49.
5. Header N = 0, then a header N = 513 -> status = BADLEN each time, no ins_mem_en pulse, core_reset held at 1.
6. Reset asserted after word 1 of 3 -> all outputs return to reset values; a new start plus a full load completes normally; start pulses during LOAD and RUN are ignored.
